fft_2d_frame_loader: RTL and testbench
======================================

// Module: fft_2d_frame_loader
// PURPOSE
//  Input stage directly upstream of the 8x8 2-D FFT top. Accepts a serial stream of complex
//  samples (valid/ready), assembles them into a full NxN frame in ping-pong storage and
//  presents the whole frame in parallel to the FFT with a frame-level valid/ready handshake.
//  Streaming into one bank overlaps with the FFT consuming the other.
// PARAMETERS
//  DW    16  sample width per component, signed two's complement (matches FFT input bus)
//  N     8   frame side; power of two; frame holds N*N samples
//  LOGN  3   log2(N)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous active-high reset
//  s_valid    in   1          input sample valid
//  s_ready    out  1          loader can accept a sample this cycle
//  s_re       in   DW         sample real part
//  s_im       in   DW         sample imaginary part
//  s_last     in   1          marks the final sample (N*N-th) of a frame
//  f_valid    out  1          complete frame available on f_re/f_im
//  f_ready    in   1          FFT takes the frame this cycle
//  f_re       out  N*N*DW     frame real parts, slot k = bits [(k+1)*DW-1 : k*DW]
//  f_im       out  N*N*DW     frame imaginary parts, same packing
//  frame_err  out  1          one-cycle pulse on s_last framing error
// BEHAVIOUR
//  - Raster order: the k-th accepted sample (k=0..N*N-1) is row r=k/N, col c=k%N; it is
//    stored in slot k, which drives FFT input in_{r+1}_{c+1}.
//  - Storage: two banks (0,1), each with a FULL flag. Write state: wr_bank, wr_cnt
//    (0..N*N-1). Read state: rd_bank.
//  - Reset: banks empty, wr_bank=rd_bank=0, wr_cnt=0, all storage cleared to 0.
//    Outputs after reset: s_ready=1, f_valid=0, f_re=f_im=0, frame_err=0.
//  - s_ready = !FULL[wr_bank], combinational from registers only. It has no path from s_valid.
//  - Accept = s_valid & s_ready. On each accept the sample is written and wr_cnt advances.
//  - Accept with wr_cnt==N*N-1: FULL[wr_bank]<=1, wr_bank toggles, wr_cnt<=0.
//    If s_last=0 here, frame_err pulses but the frame is still committed.
//  - Accept with s_last=1 and wr_cnt!=N*N-1: the partial frame is dropped, wr_cnt<=0,
//    wr_bank is unchanged, frame_err pulses for 1 cycle. The dropped sample is discarded.
//  - f_valid = FULL[rd_bank]. f_re/f_im are muxed from rd_bank. They hold stable while
//    f_valid & !f_ready.
//  - f_valid & f_ready: FULL[rd_bank]<=0, rd_bank toggles.
//  - Latency: if the last sample of a frame is accepted at edge t, that frame's bank becomes
//    FULL at edge t. f_valid is high in the cycle after edge t when that bank is rd_bank.
//  - Simultaneous events:
//    * Committing bank A while bank B is read: both take effect.
//    * The same bank cannot be written and read at once, because writes need !FULL.
//  - When both banks are full, s_ready=0 and the upstream stalls. No sample is lost.
//  - Throughput: 1 sample/cycle sustained when f_ready responds within N*N cycles.
//  - rst mid-frame: the partial frame and any full banks are discarded and the state returns
//    to reset values on the next edge.
// CONFIGURATION
//  FFT_LOADER_BITREV_EN defined:
//    sample (r,c) is stored in slot bitrev_LOGN(r)*N + bitrev_LOGN(c).
//    The FFT therefore receives bit-reversed input order on both axes.
//  Undefined:
//    natural raster order, slot = r*N + c.
//  Handshake, error and timing behaviour are identical in both builds.
// TESTING
//  1 rst 2 cycles; stream 64 samples (re=k+2, im=k+2) with s_last on k=63, f_ready=1
//    -> f_valid=1 one cycle after the last accept; slot k = k+2; f_valid drops after 1 cycle.
//  2 f_ready=0; stream 3 frames back-to-back
//    -> s_ready=0 after accept #128; f_re is stable. Set f_ready=1 for 1 cycle
//    -> s_ready=1 next cycle; the third frame completes; frames come out in order 1,2,3.
//  3 s_last asserted on sample k=9
//    -> frame_err pulses 1 cycle; wr_cnt=0; the next 64 samples form the frame.
//       Slot 0 = first sample after the error.
//  4 64 samples with no s_last
//    -> frame_err pulses on accept #64; f_valid still rises with the full frame.
//  5 rst after 30 accepted samples, then 64 fresh samples
//    -> s_ready=1 and f_valid=0 after rst; the frame contains only the fresh samples.
//  6 FFT_LOADER_BITREV_EN build; input k=1 (r0,c1, value 5) and k=8 (r1,c0, value 7)
//    -> slot 4 holds 5, slot 32 holds 7; slot 0 and slot 63 are unchanged from raster order.

Source files
------------

// File: rtl/fft_2d_frame_loader.sv
// fft_2d_frame_loader
// Collects a serial valid/ready stream of complex samples into NxN frames held
// in two ping-pong banks, and presents each completed frame in parallel to the
// 2-D FFT with a frame-level valid/ready handshake.
// Optional build macro: FFT_LOADER_BITREV_EN stores sample (r,c) in slot
// bitrev(r)*N + bitrev(c) instead of natural raster slot r*N + c.
module fft_2d_frame_loader #(
    parameter int DW   = 16,
    parameter int N    = 8,
    parameter int LOGN = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DW-1:0]         s_re,
    input  logic [DW-1:0]         s_im,
    input  logic                  s_last,
    output logic                  f_valid,
    input  logic                  f_ready,
    output logic [N*N*DW-1:0]     f_re,
    output logic [N*N*DW-1:0]     f_im,
    output logic                  frame_err
);
    localparam int NN = N * N;
    localparam int CW = 2 * LOGN;
    localparam logic [CW-1:0] CNT_MAX = CW'(NN - 1);

    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic          frame_err_q, frame_err_d;

    logic [DW-1:0] re_mem_q [0:1][0:NN-1];
    logic [DW-1:0] im_mem_q [0:1][0:NN-1];

    logic          accept;
    logic          cnt_last;
    logic          commit;
    logic          drop;
    logic          take;
    logic          wr_en;
    logic [CW-1:0] wr_slot;

    // Handshake decode; s_ready depends on registers only
    assign s_ready  = !full_q[wr_bank_q];
    assign f_valid  = full_q[rd_bank_q];
    assign accept   = s_valid & s_ready;
    assign cnt_last = (wr_cnt_q == CNT_MAX);
    assign commit   = accept & cnt_last;
    assign drop     = accept & s_last & !cnt_last;
    assign take     = f_valid & f_ready;
    // A sample carrying an early s_last is thrown away with its partial frame
    assign wr_en    = accept & !drop;
    assign frame_err = frame_err_q;

    // Slot address for the sample being written
    genvar gi;
    generate
`ifdef FFT_LOADER_BITREV_EN
        for (gi = 0; gi < LOGN; gi++) begin : g_bitrev
            assign wr_slot[LOGN + gi] = wr_cnt_q[CW - 1 - gi];
            assign wr_slot[gi]        = wr_cnt_q[LOGN - 1 - gi];
        end
`else
        assign wr_slot = wr_cnt_q;
`endif
    endgenerate

    // Parallel frame presentation, muxed from the bank being read
    generate
        for (gi = 0; gi < NN; gi++) begin : g_out
            assign f_re[gi*DW +: DW] = re_mem_q[rd_bank_q][gi];
            assign f_im[gi*DW +: DW] = im_mem_q[rd_bank_q][gi];
        end
    endgenerate

    // Next-state for bank flags, write/read pointers and error pulse
    always_comb begin
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        frame_err_d = (commit & !s_last) | drop;
        // Read and write never hit the same bank: writing needs it empty, reading needs it full
        if (take) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
        if (commit) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wr_cnt_d          = '0;
        end else if (drop) begin
            wr_cnt_d = '0;
        end else if (accept) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Frame storage; cleared on reset so the FFT bus reads zero until a frame lands
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < NN; k++) begin
                    re_mem_q[b][k] <= '0;
                    im_mem_q[b][k] <= '0;
                end
            end
        end else if (wr_en) begin
            re_mem_q[wr_bank_q][wr_slot] <= s_re;
            im_mem_q[wr_bank_q][wr_slot] <= s_im;
        end
    end

endmodule

// File: tb/tb_fft_2d_frame_loader.sv
// Testbench for fft_2d_frame_loader: directed scenarios plus randomized traffic,
// checked against a frame-level queue model of the loader.
module tb_fft_2d_frame_loader;
    localparam int DW   = 16;
    localparam int N    = 8;
    localparam int LOGN = 3;
    localparam int NN   = N * N;
    localparam int FW   = NN * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_re;
    logic [DW-1:0] s_im;
    logic          s_last;
    logic          f_valid;
    logic          f_ready;
    logic [FW-1:0] f_re;
    logic [FW-1:0] f_im;
    logic          frame_err;

    fft_2d_frame_loader #(.DW(DW), .N(N), .LOGN(LOGN)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_re      (s_re),
        .s_im      (s_im),
        .s_last    (s_last),
        .f_valid   (f_valid),
        .f_ready   (f_ready),
        .f_re      (f_re),
        .f_im      (f_im),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: completed frames waiting for the FFT, plus the frame being assembled
    logic [FW-1:0] fq_re [$];
    logic [FW-1:0] fq_im [$];
    logic [FW-1:0] part_re;
    logic [FW-1:0] part_im;
    int            m_cnt;
    logic          m_err;

    task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        int slot;
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            slot = 0;
            for (int k = NN - 1; k >= 0; k--)
                if (got[k*DW +: DW] !== exp[k*DW +: DW]) slot = k;
            $display("FAIL %s: slot %0d got %0h expected %0h", tag, slot,
                     got[slot*DW +: DW], exp[slot*DW +: DW]);
        end
    endtask

    function automatic int rev_bits(input int x);
        int o = 0;
        for (int i = 0; i < LOGN; i++)
            if (((x >> i) & 1) != 0) o |= 1 << (LOGN - 1 - i);
        return o;
    endfunction

    // Where the k-th sample of a frame lands
    function automatic int slot_of(input int k);
        int r = k / N;
        int c = k % N;
`ifdef FFT_LOADER_BITREV_EN
        r = rev_bits(r);
        c = rev_bits(c);
`endif
        return r * N + c;
    endfunction

    task automatic model_clear();
        fq_re.delete();
        fq_im.delete();
        part_re = '0;
        part_im = '0;
        m_cnt   = 0;
        m_err   = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs before the edge, advance model, check error pulse
    task automatic cycle(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im,
                         input logic last, input logic fr, output logic acc);
        logic exp_ready;
        logic exp_fv;
        logic take;
        s_valid = v;
        s_re    = re;
        s_im    = im;
        s_last  = last;
        f_ready = fr;
        exp_ready = (fq_re.size() < 2);
        exp_fv    = (fq_re.size() > 0);
        chk("s_ready", FW'(s_ready), FW'(exp_ready));
        chk("f_valid", FW'(f_valid), FW'(exp_fv));
        if (exp_fv) begin
            chk("f_re", f_re, fq_re[0]);
            chk("f_im", f_im, fq_im[0]);
        end
        acc  = v & exp_ready;
        take = exp_fv & fr;
        @(posedge clk);
        m_err = 1'b0;
        if (take) begin
            void'(fq_re.pop_front());
            void'(fq_im.pop_front());
        end
        if (acc) begin
            if (m_cnt == NN - 1) begin
                part_re[slot_of(m_cnt)*DW +: DW] = re;
                part_im[slot_of(m_cnt)*DW +: DW] = im;
                fq_re.push_back(part_re);
                fq_im.push_back(part_im);
                m_err = !last;
                m_cnt = 0;
            end else if (last) begin
                m_err = 1'b1;
                m_cnt = 0;
            end else begin
                part_re[slot_of(m_cnt)*DW +: DW] = re;
                part_im[slot_of(m_cnt)*DW +: DW] = im;
                m_cnt++;
            end
        end
        @(negedge clk);
        chk("frame_err", FW'(frame_err), FW'(m_err));
        $display("cyc v=%0b acc=%0b last=%0b fr=%0b take=%0b cnt=%0d queued=%0d err=%0b",
                 v, acc, last, fr, take, m_cnt, fq_re.size(), m_err);
    endtask

    // Offer one sample until accepted, within a cycle budget
    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im,
                        input logic last, input logic fr);
        logic a = 1'b0;
        for (int t = 0; t < 200 && !a; t++) cycle(1'b1, re, im, last, fr, a);
        if (!a) chk("send_timeout", FW'(0), FW'(1));
    endtask

    task automatic idle(input int n, input logic fr);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, fr, a);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_re    = '0;
        s_im    = '0;
        s_last  = 1'b0;
        f_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        chk("rst_s_ready", FW'(s_ready), FW'(1));
        chk("rst_f_valid", FW'(f_valid), FW'(0));
        chk("rst_f_re", f_re, '0);
        chk("rst_f_im", f_im, '0);
        chk("rst_frame_err", FW'(frame_err), FW'(0));
        $display("reset done");
    endtask

    initial begin
        logic a;
        int acc_n;
        int stall;
        do_reset();

        // 1: counting frame, consumer always ready
        for (int k = 0; k < NN; k++) send(DW'(k + 2), DW'(k + 2), k == NN - 1, 1'b1);
        idle(3, 1'b1);

        // 2: three frames back-to-back against a stalled consumer, released one cycle at a time
        acc_n = 0;
        stall = 0;
        for (int it = 0; it < 1000 && acc_n < 3 * NN; it++) begin
            cycle(1'b1, DW'($urandom), DW'($urandom), (acc_n % NN) == NN - 1, stall == 4, a);
            if (stall == 4) stall = 0;
            else if (!a) stall++;
            if (a) acc_n++;
        end
        if (acc_n < 3 * NN) chk("t2_timeout", FW'(acc_n), FW'(3 * NN));
        idle(4, 1'b1);

        // 3: early s_last on k=9, then a full frame
        for (int k = 0; k < 10; k++) send(DW'($urandom), DW'($urandom), k == 9, 1'b1);
        for (int k = 0; k < NN; k++) send(DW'($urandom), DW'($urandom), k == NN - 1, 1'b1);
        idle(2, 1'b1);

        // 4: full frame with s_last missing
        for (int k = 0; k < NN; k++) send(DW'($urandom), DW'($urandom), 1'b0, 1'b1);
        idle(2, 1'b1);

        // 5: reset mid-frame, then a fresh frame
        for (int k = 0; k < 30; k++) send(DW'($urandom), DW'($urandom), 1'b0, 1'b1);
        do_reset();
        for (int k = 0; k < NN; k++) send(DW'(k + 1000), DW'(k + 2000), k == NN - 1, 1'b1);
        idle(2, 1'b1);

        // 6: slot placement of (r0,c1) and (r1,c0), held with consumer stalled
        for (int k = 0; k < NN; k++)
            send((k == 1) ? DW'(5) : (k == 8) ? DW'(7) : DW'(k + 100), DW'(k), k == NN - 1, 1'b0);
        chk("t6_f_valid", FW'(f_valid), FW'(1));
`ifdef FFT_LOADER_BITREV_EN
        chk("t6_slot4", FW'(f_re[4*DW +: DW]), FW'(5));
        chk("t6_slot32", FW'(f_re[32*DW +: DW]), FW'(7));
`else
        chk("t6_slot1", FW'(f_re[1*DW +: DW]), FW'(5));
        chk("t6_slot8", FW'(f_re[8*DW +: DW]), FW'(7));
`endif
        chk("t6_slot0", FW'(f_re[0 +: DW]), FW'(100));
        chk("t6_slot63", FW'(f_re[63*DW +: DW]), FW'(163));
        idle(2, 1'b1);

        // 7: random valid gaps, random consumer, occasional framing errors
        for (int it = 0; it < 2000; it++) begin
            cycle(($urandom % 4) != 0, DW'($urandom), DW'($urandom),
                  (m_cnt == NN - 1) ? (($urandom % 8) != 0) : (($urandom % 150) == 0),
                  ($urandom % 3) != 0, a);
        end
        idle(4, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
